pipe_stall_ctrl: RTL
====================

# pipe_stall_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives the enables of the fetch and decode pipeline registers (StallF, StallD) and the execute-stage flush (FlushE). Produces all forwarding selects. Owns a small FSM that sequences the multi-cycle multiply/divide unit and holds dependent instructions in decode until HI/LO is written.

## Interface
Parameters:
- MUL_CYCLES, 4, busy cycles of a multiply (≥1)
- DIV_CYCLES, 32, busy cycles of a divide (≥1)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- rsD, rtD  in  5  decode-stage source registers
- rsE, rtE  in  5  execute-stage source registers
- writeregE, writeregM, writeregW  in  5  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage
- memtoregE, memtoregM  in  1  load in E / load in M
- branchD  in  1  branch resolving in decode
- mdstartD  in  1  mult/div instruction in decode
- hiloreadD  in  1  mfhi/mflo in decode
- mdstartE  in  1  mult/div instruction in execute (launch)
- mdopE  in  1  0 = multiply, 1 = divide
- StallF  out  1  active-high stall; PC register enable = ~StallF
- StallD  out  1  active-high stall of the F→D register
- FlushE  out  1  clear the D→E register (insert bubble)
- ForwardAD, ForwardBD  out  1  forward ALUOutM into decode comparator
- ForwardAE, ForwardBE  out  2  00 register file, 01 ResultW, 10 ALUOutM
- mdbusy  out  1  mult/div unit occupied (state ≠ IDLE)
- mdwe  out  1  write HI/LO this cycle

## Operation
- Register 0 never matches: every comparison below requires the register to be ≠ 0.
- ForwardAE = 10 if regwriteM and writeregM==rsE; otherwise 01 if regwriteW and writeregW==rsE; otherwise 00. M has priority over W. ForwardBE is identical using rtE.
- ForwardAD = regwriteM and writeregM==rsD. ForwardBD is the same using rtD.
- lwstall = memtoregE and writeregE∈{rsD,rtD}.
- branchstall = branchD and ((regwriteE and writeregE∈{rsD,rtD}) or (memtoregM and writeregM∈{rsD,rtD})).
- mdstall = mdbusy and (hiloreadD or mdstartD).
- StallF = StallD = FlushE = lwstall | branchstall | mdstall. These are combinational from inputs and state.
- FSM states:
  - IDLE: on mdstartE, go to BUSY and load cnt ← (mdopE ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY: if cnt==0, go to DONE; otherwise cnt ← cnt−1.
  - DONE: mdwe=1; always go to IDLE next cycle.
- mdstartE in BUSY or DONE cannot occur legally, because mdstall blocks it. It is ignored, and state and cnt are unchanged.
- cnt width is $clog2(max(MUL_CYCLES, DIV_CYCLES)), minimum 1 bit.

## Timing
- Reset value, sampled at an edge with reset=1: state IDLE, cnt 0.
- Outputs while in reset and after it: mdbusy=0, mdwe=0, mdstall=0. The other outputs follow their combinational equations.
- Reset mid-operation (BUSY or DONE): IDLE at the next edge. No mdwe pulse is produced afterwards.
- Launch latency: mdstartE sampled at edge 0 gives BUSY for exactly N cycles (cycles 1..N), DONE (mdwe=1) in cycle N+1, and IDLE in cycle N+2.
- A dependent mfhi in decode stalls through cycle N+1 and advances in cycle N+2.
- All stall/flush/forward outputs respond in the same cycle as their inputs; there are no registered outputs except mdbusy and mdwe.
- Simultaneous hazards are ORed; there is no priority among stall sources.

## Test plan
- Load-use: memtoregE=1, writeregE=8, rsD=8 → StallF=StallD=FlushE=1. Change to writeregE=0 with rsD=0 → all 0.
- Forwarding priority: regwriteM=regwriteW=1, writeregM=writeregW=rsE=5 → ForwardAE=10. Then regwriteM=0 → 01. Then rsE=0 → 00.
- Branch: branchD=1, regwriteE=1, writeregE=rtD=9 → stall=1. With memtoregM=1 and writeregM=rsD=3 instead → stall=1. With regwriteM=1 and writeregM=rsD=3 (not a load) → stall=0 and ForwardAD=1.
- Multiply: mdstartE=1, mdopE=0 at edge 0, with hiloreadD held high → mdbusy=1 in cycles 1..5, mdwe=1 only in cycle 5, StallF=1 in cycles 1..5, StallF=0 in cycle 6.
- Divide: mdopE=1 → mdbusy for 33 cycles, with mdwe in cycle 33. A mdstartD during BUSY stalls. A mdstartE asserted during BUSY leaves cnt unchanged.
- Reset mid-divide: assert reset in cycle 10 for one edge → mdbusy=0 from cycle 11, and mdwe is never asserted.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: stall/flush,
// forwarding selects, and the mult/div busy sequencer that guards HI/LO reads.
//
// state  | meaning
// S_IDLE | mult/div unit free, waiting for a launch from execute
// S_BUSY | operation in flight, r_cnt counts remaining busy cycles down to 0
// S_DONE | result ready, HI/LO written this cycle (mdwe)
module pipe_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       mdstartD,
    input  logic       hiloreadD,
    input  logic       mdstartE,
    input  logic       mdopE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mdbusy,
    output logic       mdwe
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic w_lwstall;
    logic w_branchstall;
    logic w_mdstall;
    logic w_stall;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (mdstartE) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = mdopE ? DIV_LOAD : MUL_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gated by reset so a pending result is never exposed while reset is held.
    assign mdbusy = ~reset & (r_state != S_IDLE);
    assign mdwe   = ~reset & (r_state == S_DONE);

    always_comb begin
        ForwardAE = 2'b00;
        if (regwriteM && reg_match(writeregM, rsE)) begin
            ForwardAE = 2'b10;
        end else if (regwriteW && reg_match(writeregW, rsE)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (regwriteM && reg_match(writeregM, rtE)) begin
            ForwardBE = 2'b10;
        end else if (regwriteW && reg_match(writeregW, rtE)) begin
            ForwardBE = 2'b01;
        end
    end

    assign ForwardAD = regwriteM & reg_match(writeregM, rsD);
    assign ForwardBD = regwriteM & reg_match(writeregM, rtD);

    assign w_lwstall     = memtoregE & (reg_match(writeregE, rsD) | reg_match(writeregE, rtD));
    assign w_branchstall = branchD &
                           ((regwriteE & (reg_match(writeregE, rsD) | reg_match(writeregE, rtD))) |
                            (memtoregM & (reg_match(writeregM, rsD) | reg_match(writeregM, rtD))));
    assign w_mdstall     = mdbusy & (hiloreadD | mdstartD);
    assign w_stall       = w_lwstall | w_branchstall | w_mdstall;

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;

endmodule
